cache_mem_arb: RTL and testbench

Sequencer and arbiter in front of the single-port 256x32 cache data SRAM wrapper (cache_mem). It shares the SRAM between two requesters: port 0 is the lookup/hit path and port 1 is the refill/eviction path. Arbitration is round-robin with a valid/ready handshake, and each requester receives read data through its own response strobe. After reset or flush, the block runs an init sequence that zero-fills the whole array before any requester is accepted.

---
 rtl/cache_mem_arb_if.sv | 51 +++++
 rtl/cache_mem_arb.sv | 111 +++++++++++
 tb/tb_cache_mem_arb.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arb_if.sv
// Request/response/SRAM signal bundle for cache_mem_arb.
// The slave modport is the arbiter's view; master is the requesters' and SRAM's view.
interface cache_mem_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              i_flush;
  logic              o_init_done;

  logic              i_req0_valid;
  logic              i_req0_write;
  logic [ADDR_W-1:0] i_req0_addr;
  logic [DATA_W-1:0] i_req0_data;
  logic              o_req0_ready;

  logic              i_req1_valid;
  logic              i_req1_write;
  logic [ADDR_W-1:0] i_req1_addr;
  logic [DATA_W-1:0] i_req1_data;
  logic              o_req1_ready;

  logic              o_rsp0_valid;
  logic              o_rsp1_valid;
  logic [DATA_W-1:0] o_rsp_data;

  logic              o_mem_enable;
  logic              o_mem_write;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_data;
  logic [DATA_W-1:0] i_mem_data;

  modport slave (
    input  i_flush,
    input  i_req0_valid, i_req0_write, i_req0_addr, i_req0_data,
    input  i_req1_valid, i_req1_write, i_req1_addr, i_req1_data,
    input  i_mem_data,
    output o_init_done, o_req0_ready, o_req1_ready,
    output o_rsp0_valid, o_rsp1_valid, o_rsp_data,
    output o_mem_enable, o_mem_write, o_mem_addr, o_mem_data
  );

  modport master (
    output i_flush,
    output i_req0_valid, i_req0_write, i_req0_addr, i_req0_data,
    output i_req1_valid, i_req1_write, i_req1_addr, i_req1_data,
    output i_mem_data,
    input  o_init_done, o_req0_ready, o_req1_ready,
    input  o_rsp0_valid, o_rsp1_valid, o_rsp_data,
    input  o_mem_enable, o_mem_write, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/cache_mem_arb.sv
// Two-port round-robin sequencer for the single-port cache data SRAM, with a
// zero-fill init sequence after reset or flush.
module cache_mem_arb #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int INIT_ON_RESET = 1
) (
  input logic           i_clk,
  input logic           i_nreset,
  cache_mem_arb_if.slave bus
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RST  = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last1_q, last1_d;   // 1 = port 1 was granted last
  logic             rsp0_q, rsp0_d;
  logic             rsp1_q, rsp1_d;

  logic flush_eff;
  logic accept_en;
  logic grant0;
  logic grant1;

  assign flush_eff = bus.i_flush && (INIT_ON_RESET != 0);
  // Reset gating keeps readies and SRAM strobes quiet while i_nreset is low.
  assign accept_en = i_nreset && (state_q == ST_RUN) && !flush_eff;

  assign grant0 = accept_en && bus.i_req0_valid && (!bus.i_req1_valid || last1_q);
  assign grant1 = accept_en && bus.i_req1_valid && (!bus.i_req0_valid || !last1_q);

  assign bus.o_req0_ready = grant0;
  assign bus.o_req1_ready = grant1;
  assign bus.o_init_done  = i_nreset && (state_q == ST_RUN);
  assign bus.o_rsp0_valid = rsp0_q;
  assign bus.o_rsp1_valid = rsp1_q;
  assign bus.o_rsp_data   = bus.i_mem_data;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave a latch behind.
  always_comb begin
    bus.o_mem_enable = 1'b0;
    bus.o_mem_write  = 1'b0;
    bus.o_mem_addr   = '0;
    bus.o_mem_data   = '0;
    if (i_nreset && (state_q == ST_INIT)) begin
      bus.o_mem_enable = 1'b1;
      bus.o_mem_write  = 1'b1;
      bus.o_mem_addr   = cnt_q[ADDR_W-1:0];
    end else if (grant0) begin
      bus.o_mem_enable = 1'b1;
      bus.o_mem_write  = bus.i_req0_write;
      bus.o_mem_addr   = bus.i_req0_addr;
      bus.o_mem_data   = bus.i_req0_data;
    end else if (grant1) begin
      bus.o_mem_enable = 1'b1;
      bus.o_mem_write  = bus.i_req1_write;
      bus.o_mem_addr   = bus.i_req1_addr;
      bus.o_mem_data   = bus.i_req1_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last1_d = last1_q;
    rsp0_d  = grant0 && !bus.i_req0_write;
    rsp1_d  = grant1 && !bus.i_req1_write;
    if (grant0) last1_d = 1'b0;
    if (grant1) last1_d = 1'b1;
    if (state_q == ST_INIT) begin
      if (flush_eff) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (flush_eff) begin
      cnt_d   = '0;
      state_d = ST_INIT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      last1_q <= 1'b1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last1_q <= last1_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arb.sv
// Directed bench for cache_mem_arb: a behavioural SRAM behind dut_a, a scoreboard
// of expected read responses, and a second instance with INIT_ON_RESET=0.
module tb_cache_mem_arb;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic nreset_a = 1'b0;
  logic nreset_b = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a ();
  cache_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b ();

  cache_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_ON_RESET(1)) dut_a (
    .i_clk(clk), .i_nreset(nreset_a), .bus(a)
  );
  cache_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_ON_RESET(0)) dut_b (
    .i_clk(clk), .i_nreset(nreset_b), .bus(b)
  );

  // Behavioural single-port SRAM: read data valid the cycle after the enable.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] mem_rdata = '0;
  always @(posedge clk) begin
    if (a.o_mem_enable) begin
      if (a.o_mem_write) mem[a.o_mem_addr] <= a.o_mem_data;
      else               mem_rdata <= mem[a.o_mem_addr];
    end
  end
  assign a.i_mem_data = mem_rdata;
  assign b.i_mem_data = '0;

  typedef struct {
    bit                port;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after the accepting edge; the response is due in this cycle.
  task automatic push(input bit port, input logic [DATA_W-1:0] data);
    sb.push_back('{port: port, data: data, due: cyc});
  endtask

  always @(negedge clk) begin
    if (a.o_rsp0_valid || a.o_rsp1_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {a.o_rsp0_valid, a.o_rsp1_valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_port", {a.o_rsp0_valid, a.o_rsp1_valid}, mon_e.port ? 64'd1 : 64'd2);
        check("rsp_data", a.o_rsp_data, mon_e.data);
        check("rsp_cycle", cyc, mon_e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      check("rsp_missing", {a.o_rsp0_valid, a.o_rsp1_valid}, mon_e.port ? 64'd1 : 64'd2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    a.i_flush = 0;
    a.i_req0_valid = 0; a.i_req0_write = 0; a.i_req0_addr = '0; a.i_req0_data = '0;
    a.i_req1_valid = 0; a.i_req1_write = 0; a.i_req1_addr = '0; a.i_req1_data = '0;
  endtask

  task automatic req0(input bit wr, input logic [7:0] addr, input logic [31:0] data);
    a.i_req0_valid = 1; a.i_req0_write = wr; a.i_req0_addr = addr; a.i_req0_data = data;
  endtask

  task automatic req1(input bit wr, input logic [7:0] addr, input logic [31:0] data);
    a.i_req1_valid = 1; a.i_req1_write = wr; a.i_req1_addr = addr; a.i_req1_data = data;
  endtask

  // One granted single-port access: check the grant and SRAM drive, then accept.
  task automatic single(input bit port, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd);
    clear_a();
    if (port) req1(wr, addr, data); else req0(wr, addr, data);
    @(negedge clk);
    check("single_grant",
          {a.o_req0_ready, a.o_req1_ready, a.o_mem_enable, a.o_mem_write, a.o_mem_addr},
          {!port, port, 1'b1, wr, addr});
    step();
    if (!wr) push(port, exp_rd);
    clear_a();
  endtask

  // Walk the zero-fill from address 0 up to last_k with both ports requesting.
  task automatic check_fill(input int last_k);
    a.i_req0_valid = 1;
    a.i_req1_valid = 1;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      check("init_word",
            {a.o_mem_enable, a.o_mem_write, a.o_mem_addr, a.o_mem_data,
             a.o_req0_ready, a.o_req1_ready, a.o_init_done},
            {1'b1, 1'b1, 8'(k), 32'h0, 3'b000});
    end
  endtask

  task automatic check_init();
    check_fill(255);
    @(negedge clk);
    check("init_done_rise", a.o_init_done, 64'd1);
    clear_a();
  endtask

  initial begin
    clear_a();
    b.i_flush = 0;
    b.i_req0_valid = 0; b.i_req0_write = 0; b.i_req0_addr = '0; b.i_req0_data = '0;
    b.i_req1_valid = 1; b.i_req1_write = 1; b.i_req1_addr = 8'h07; b.i_req1_data = 32'h1234;
    a.i_req0_valid = 1;
    a.i_req1_valid = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {a.o_mem_enable, a.o_req0_ready, a.o_req1_ready, a.o_init_done,
                      a.o_rsp0_valid, a.o_rsp1_valid}, 64'd0);
    check("reset_b", {b.o_mem_enable, b.o_req1_ready, b.o_init_done}, 64'd0);

    // Zero-fill after reset release, then a read of a filled word.
    step();
    nreset_a = 1;
    check_init();
    step();
    single(0, 0, 8'hA5, 32'h0, 32'h0);

    // Write through port 1, read back through port 0.
    single(1, 1, 8'h3C, 32'hDEADBEEF, 32'h0);
    single(0, 0, 8'h3C, 32'h0, 32'hDEADBEEF);

    // Seed two words; port 1 is granted last, so the contest starts with port 0.
    single(0, 1, 8'h10, 32'h11111111, 32'h0);
    single(1, 1, 8'h20, 32'h22222222, 32'h0);
    clear_a();
    req0(0, 8'h10, 32'h0);
    req1(0, 8'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("alternate",
            {a.o_req0_ready, a.o_req1_ready, a.o_mem_enable, a.o_mem_addr},
            {(i % 2) == 0, (i % 2) == 1, 1'b1, ((i % 2) == 1) ? 8'h20 : 8'h10});
      step();
      push(i % 2, ((i % 2) == 1) ? 32'h22222222 : 32'h11111111);
    end
    clear_a();

    // Read accepted, then flush the next cycle while both ports still request.
    single(1, 1, 8'h55, 32'hCAFEF00D, 32'h0);
    single(0, 0, 8'h55, 32'h0, 32'hCAFEF00D);
    a.i_flush = 1;
    req0(0, 8'h10, 32'h0);
    req1(0, 8'h20, 32'h0);
    @(negedge clk);
    check("flush_cycle", {a.o_req0_ready, a.o_req1_ready, a.o_mem_enable, a.o_init_done},
          {4'b0001});
    step();
    a.i_flush = 0;
    check_init();
    step();
    single(0, 0, 8'h3C, 32'h0, 32'h0);
    single(1, 0, 8'h55, 32'h0, 32'h0);
    single(0, 0, 8'h10, 32'h0, 32'h0);

    // Reset in the middle of the zero-fill.
    single(1, 1, 8'h20, 32'h5A5A5A5A, 32'h0);
    a.i_flush = 1;
    step();
    a.i_flush = 0;
    check_fill(100);
    #1;
    nreset_a = 0;
    #1;
    check("reset_mid_init",
          {a.o_mem_enable, a.o_mem_write, a.o_mem_addr, a.o_mem_data, a.o_req0_ready,
           a.o_req1_ready, a.o_init_done, a.o_rsp0_valid, a.o_rsp1_valid}, 64'd0);
    step();
    nreset_a = 1;
    check_init();
    step();
    single(1, 0, 8'h20, 32'h0, 32'h0);

    // INIT_ON_RESET=0: straight to RUN, flush has no effect.
    nreset_b = 1;
    @(negedge clk);
    check("b_first_cycle", {b.o_req1_ready, b.o_init_done, b.o_mem_enable, b.o_mem_write,
                            b.o_mem_addr}, {4'b1111, 8'h07});
    step();
    b.i_flush = 1;
    @(negedge clk);
    check("b_flush_cycle", {b.o_req1_ready, b.o_init_done, b.o_mem_enable}, 64'd7);
    step();
    b.i_flush = 0;
    @(negedge clk);
    check("b_after_flush", {b.o_req1_ready, b.o_init_done, b.o_mem_write}, 64'd7);

    repeat (3) step();
    check("sb_drain", sb.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
